// File: rtl/msg_arb_pkg.sv
// rtl/msg_arb_pkg.sv - shared types and default constants for the message arbiter
package msg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/msg_arbiter_rr_pick.sv
// rtl/msg_arbiter_rr_pick.sv - combinational round-robin selector starting at ptr
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // scan from ptr upward, wrapping, and keep the first requester seen
  always_comb begin
    int c;
    found = 1'b0;
    index = '0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        index = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/msg_arbiter.sv
// rtl/msg_arbiter.sv - packet-granular round-robin arbiter with stall timeout
module msg_arbiter
  import msg_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [$clog2(N_REQ)-1:0]  out_src,
  input  logic                      out_ready,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      abort_pulse
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int SW    = $clog2(TIMEOUT + 1);

  arb_state_t       state, next_state;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] g_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [SW-1:0]    stall_cnt;
  logic             abort_q;
  logic             g_valid;
  logic             g_last;
  logic [DATA_W-1:0] g_data;
  logic             last_xfer;
  logic             stall_hit;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // select the granted requester's beat; g is always below N_REQ
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g == IDX_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // end-of-grant events: last beat accepted, or the stall counter about to hit TIMEOUT
  always_comb begin
    last_xfer = (state == BUSY) && g_valid && out_ready && g_last;
    stall_hit = (state == BUSY) && !g_valid && (stall_cnt == SW'(TIMEOUT - 1));
    g_next    = (g == IDX_W'(N_REQ - 1)) ? '0 : g + IDX_W'(1);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // grant index, round-robin pointer, stall counter and abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      g         <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= stall_hit;
      if (state == IDLE) begin
        stall_cnt <= '0;
        if (pick_found) g <= pick_idx;
      end else begin
        if (last_xfer || stall_hit) rr_ptr <= g_next;
        // backpressure keeps valid high, so it clears rather than advances the count
        if (g_valid || stall_hit) stall_cnt <= '0;
        else                      stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = BUSY;
      BUSY:    if (last_xfer || stall_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // outputs: zero-latency pass-through of the granted requester while BUSY
  always_comb begin
    busy        = (state == BUSY);
    abort_pulse = abort_q;
    grant       = '0;
    req_ready   = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    out_src     = '0;
    if (state == BUSY) begin
      out_valid = g_valid;
      out_data  = g_data;
      out_last  = g_last;
      out_src   = g;
      for (int i = 0; i < N_REQ; i++) begin
        if (g == IDX_W'(i)) begin
          grant[i]     = 1'b1;
          req_ready[i] = out_ready;
        end
      end
    end
  end

endmodule

// File: doc/msg_arbiter.md
MSG_ARBITER -- requirements
Module: msg_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..16).
REQ-002 SHALL have parameter DATA_W, default 8: character width per beat.
REQ-003 SHALL have parameter TIMEOUT, default 16: consecutive mid-packet idle cycles from the granted requester before abort.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, N_REQ: per-requester beat valid.
REQ-007 SHALL have port req_data, input, N_REQ*DATA_W: requester i occupies [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_last, input, N_REQ: final beat of the requester's packet.
REQ-009 SHALL have port req_ready, output, N_REQ: per-requester beat accept.
REQ-010 SHALL have port out_valid, output, 1: shared sink beat valid.
REQ-011 SHALL have port out_data, output, DATA_W: shared sink data.
REQ-012 SHALL have port out_last, output, 1: shared sink end of packet.
REQ-013 SHALL have port out_src, output, clog2(N_REQ): index of the granted requester.
REQ-014 SHALL have port out_ready, input, 1: sink accept.
REQ-015 SHALL have port grant, output, N_REQ: one-hot current grant; zero when idle.
REQ-016 SHALL have port busy, output, 1: high while in BUSY.
REQ-017 SHALL have port abort_pulse, output, 1: one-cycle pulse on timeout abort.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-019 In IDLE with any req_valid set, SHALL register the grant as the first valid index at or after rr_ptr, modulo N_REQ, and enter BUSY on the next cycle; arbitration latency is 1 cycle.
REQ-020 In IDLE, SHALL drive grant=0, out_valid=0, req_ready=0.
REQ-021 In BUSY with granted index g, SHALL drive out_valid=req_valid[g], out_data and out_last from g, out_src=g, combinationally with zero latency.
REQ-022 SHALL drive req_ready[i] = BUSY & (i==g) & out_ready; all non-granted ready bits 0.
REQ-023 A beat transfers when out_valid & out_ready; the grant SHALL be held across beats until a transfer with out_last=1.
REQ-024 On a last-beat transfer, SHALL return to IDLE and set rr_ptr=(g+1) mod N_REQ; the next grant is issued no earlier than 1 cycle later.
REQ-025 The stall counter SHALL increment each BUSY cycle with req_valid[g]=0, clear on any cycle with req_valid[g]=1, and clear on entry to BUSY.
REQ-026 Sink backpressure (out_ready=0 with out_valid=1) SHALL NOT advance the stall counter.
REQ-027 When the stall counter reaches TIMEOUT, SHALL assert abort_pulse for exactly 1 cycle, return to IDLE and set rr_ptr=(g+1) mod N_REQ.
REQ-028 A transfer and a timeout cannot coincide because a transfer requires valid; no precedence rule is needed.
REQ-029 A single requester with continuous packets SHALL be re-granted after each 1-cycle IDLE gap when no other requester is valid.

Reset
REQ-030 While rst=1, SHALL force state=IDLE, rr_ptr=0, stall counter=0, grant=0, out_valid=0, req_ready=0, out_src=0, busy=0, abort_pulse=0.
REQ-031 Reset mid-packet SHALL drop the grant at the next edge with no abort_pulse; the partial packet is discarded upstream.

Structure
REQ-032 Package msg_arb_pkg SHALL hold the state enum {IDLE, BUSY} and default parameter constants.
REQ-033 The round-robin selector SHALL be a combinational sub-module rr_pick (inputs: request vector, rr_ptr; outputs: found, index).
REQ-034 Implementation SHALL fit within 120-400 lines of RTL.

Verification
REQ-035 Reset, then req_valid=0001 with a 3-beat packet "H","i","!" and out_ready=1 -> grant=0001 from cycle 2, 3 beats out with out_src=0, last on "!", then IDLE.
REQ-036 All four requesters valid, each sending 1-beat packets -> grant order 0,1,2,3,0 with exactly one IDLE cycle between grants.
REQ-037 Requester 2 mid-packet drops valid for 16 cycles, TIMEOUT=16 -> abort_pulse high for 1 cycle, then grant goes to requester 3.
REQ-038 out_ready held low for 40 cycles mid-packet while req_valid[g]=1 -> no abort, data held stable, and the packet completes once ready returns.
REQ-039 rst asserted during beat 2 of 4 -> next cycle grant=0 and out_valid=0; after release, arbitration restarts from rr_ptr=0.
REQ-040 A req_valid bit set for a non-granted requester during BUSY -> req_ready stays 0 for that requester until it is granted.
